// File: rtl/sd_cmd_sequencer.sv
`default_nettype none
// ---- sd_cmd_sequencer : issues CMD0/CMD7/CMD17 as register-write frames and polls completion status (rev 1.0) ----
module sd_cmd_sequencer #(
  parameter int          CMD0_WAIT    = 250,
  parameter logic [15:0] RCA          = 16'h0013,
  parameter logic [7:0]  CMD7_SET     = 8'h00,
  parameter logic [7:0]  CMD17_SET    = 8'h3D,
  parameter logic [6:0]  STATUS_ADDR  = 7'd6,
  parameter int          POLL_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rstn_async,
  input  logic        init_req,
  input  logic        rd_req,
  input  logic [31:0] rd_blk_addr,
  input  logic [7:0]  reg_rdata,
  output logic [6:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_SETUP   = 3'd1;
  localparam logic [2:0] S_WR_STROBE  = 3'd2;
  localparam logic [2:0] S_WAIT_FIXED = 3'd3;
  localparam logic [2:0] S_POLL_ADDR  = 3'd4;
  localparam logic [2:0] S_POLL_CHK   = 3'd5;
  localparam logic [2:0] S_FINISH     = 3'd6;

  localparam logic [1:0] C_CMD0  = 2'd0;
  localparam logic [1:0] C_CMD7  = 2'd1;
  localparam logic [1:0] C_CMD17 = 2'd2;

  localparam int WW = $clog2(CMD0_WAIT + 1);
  localparam int PW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(CMD0_WAIT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);

  logic [2:0]    state, state_next;
  logic          fail_next;
  logic [1:0]    cmd;
  logic [2:0]    wr_idx;
  logic [WW-1:0] wait_cnt;
  logic [PW-1:0] poll_cnt;
  logic [31:0]   blk_addr;
  logic          ready_r, fin_err, rej_err;
  logic [7:0]    wr_byte;
  logic [31:0]   arg;
  logic          unused_rdata;

  assign unused_rdata = ^reg_rdata[7:2];

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) state <= S_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    fail_next  = 1'b0;
    case (state)
      S_IDLE:       if (init_req || (rd_req && ready_r)) state_next = S_WR_SETUP;
      S_WR_SETUP:   state_next = S_WR_STROBE;
      S_WR_STROBE: begin
        if (wr_idx != 3'd5)   state_next = S_WR_SETUP;
        else if (cmd == C_CMD0) state_next = S_WAIT_FIXED;
        else                  state_next = S_POLL_ADDR;
      end
      S_WAIT_FIXED: if (wait_cnt == WAIT_LAST) state_next = S_WR_SETUP;
      S_POLL_ADDR: begin
        if (poll_cnt == POLL_LAST) begin
          state_next = S_FINISH;
          fail_next  = 1'b1;
        end else begin
          state_next = S_POLL_CHK;
        end
      end
      S_POLL_CHK: begin
        // Error bit outranks done bit when both are reported together.
        if (reg_rdata[1] || (!reg_rdata[0] && poll_cnt == POLL_LAST)) begin
          state_next = S_FINISH;
          fail_next  = 1'b1;
        end else if (reg_rdata[0]) begin
          state_next = S_FINISH;
        end else begin
          state_next = S_POLL_ADDR;
        end
      end
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      cmd      <= C_CMD0;
      wr_idx   <= 3'd0;
      wait_cnt <= '0;
      poll_cnt <= '0;
      blk_addr <= 32'd0;
      ready_r  <= 1'b0;
      fin_err  <= 1'b0;
      rej_err  <= 1'b0;
    end else begin
      rej_err <= (state == S_IDLE) && rd_req && !init_req && !ready_r;
      case (state)
        S_IDLE: begin
          wr_idx <= 3'd0;
          if (init_req) begin
            cmd     <= C_CMD0;
            ready_r <= 1'b0;
          end else if (rd_req && ready_r) begin
            cmd      <= C_CMD17;
            blk_addr <= rd_blk_addr;
          end
        end
        S_WR_STROBE: begin
          wr_idx   <= (wr_idx == 3'd5) ? 3'd0 : wr_idx + 3'd1;
          wait_cnt <= '0;
          poll_cnt <= '0;
        end
        S_WAIT_FIXED: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (state_next == S_WR_SETUP) cmd <= C_CMD7;
        end
        S_POLL_ADDR, S_POLL_CHK: begin
          poll_cnt <= poll_cnt + PW'(1);
          if (state_next == S_FINISH) begin
            fin_err <= fail_next;
            if (cmd == C_CMD7) ready_r <= !fail_next;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    arg     = 32'd0;
    wr_byte = 8'd0;
    case (cmd)
      C_CMD7:  arg = {RCA, 16'h0000};
      C_CMD17: arg = blk_addr;
      default: arg = 32'd0;
    endcase
    case (wr_idx)
      3'd0:    wr_byte = (cmd == C_CMD7) ? 8'd7 : (cmd == C_CMD17) ? 8'd17 : 8'd0;
      3'd1:    wr_byte = (cmd == C_CMD7) ? CMD7_SET : (cmd == C_CMD17) ? CMD17_SET : 8'd0;
      3'd2:    wr_byte = arg[31:24];
      3'd3:    wr_byte = arg[23:16];
      3'd4:    wr_byte = arg[15:8];
      default: wr_byte = arg[7:0];
    endcase

    reg_addr  = 7'd0;
    reg_wdata = 8'd0;
    reg_we    = 1'b0;
    case (state)
      S_WR_SETUP, S_WR_STROBE: begin
        reg_addr  = {4'd0, 3'd5 - wr_idx};
        reg_wdata = wr_byte;
        reg_we    = (state == S_WR_STROBE);
      end
      S_POLL_ADDR, S_POLL_CHK: reg_addr = STATUS_ADDR;
      default: ;
    endcase

    ready = ready_r;
    busy  = (state != S_IDLE);
    done  = (state == S_FINISH) && !fin_err;
    err   = ((state == S_FINISH) && fin_err) || rej_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sequencer.sv
`default_nettype none
// ---- tb_sd_cmd_sequencer : transaction-level checks of the SD command sequencer (rev 1.0) ----
module tb_sd_cmd_sequencer;

  localparam int          CMD0_WAIT    = 250;
  localparam logic [15:0] RCA          = 16'h0013;
  localparam logic [7:0]  CMD7_SET     = 8'h00;
  localparam logic [7:0]  CMD17_SET    = 8'h3D;
  localparam logic [6:0]  STATUS_ADDR  = 7'd6;
  localparam int          POLL_TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rstn_async = 1'b0;
  logic        init_req = 1'b0, rd_req = 1'b0;
  logic [31:0] rd_blk_addr = 32'd0;
  logic [7:0]  reg_rdata = 8'd0;
  logic [6:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we, ready, busy, done, err;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(
    .CMD0_WAIT(CMD0_WAIT), .RCA(RCA), .CMD7_SET(CMD7_SET), .CMD17_SET(CMD17_SET),
    .STATUS_ADDR(STATUS_ADDR), .POLL_TIMEOUT(POLL_TIMEOUT)
  ) dut (
    .clk(clk), .rstn_async(rstn_async), .init_req(init_req), .rd_req(rd_req),
    .rd_blk_addr(rd_blk_addr), .reg_rdata(reg_rdata), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .ready(ready), .busy(busy),
    .done(done), .err(err)
  );

  typedef struct { logic [6:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { bit is_err; int cyc; } ev_t;
  // kind: 0 init, 1 read, 2 both requests; res: 0 done, 1 err, 2 rejected
  typedef struct { int kind; logic [31:0] blk; logic [7:0] st; int resp; int res; logic rdy; } vec_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  ev_t ev_q[$];
  int  cyc = 0, origin = 0, poll_start = 0, viol = 0;
  logic       prev_we = 1'b0, prev_busy = 1'b0, prev_poll = 1'b0;
  logic [6:0] prev_addr = 7'd0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] cur_status = 8'h01;
  int  cur_resp = 1;
  int  checks = 0, errors = 0;
  bit  model_ready = 1'b0;

  // Bus monitor plus status-register responder: data for a poll appears the cycle after its address.
  always @(negedge clk) begin
    logic in_poll;
    int   offs;
    cyc++;
    in_poll = (reg_addr == STATUS_ADDR) && !reg_we;
    if (in_poll && !prev_poll) poll_start = cyc;
    if (busy && !prev_busy) origin = cyc;
    if (reg_we) begin
      got_q.push_back('{reg_addr, reg_wdata, cyc});
      if (prev_we || prev_addr != reg_addr || prev_data != reg_wdata) viol++;
    end
    if (in_poll && reg_wdata != 8'd0) viol++;
    if (!busy && (reg_we || reg_addr != 7'd0 || reg_wdata != 8'd0)) viol++;
    if (done && err) viol++;
    if (done) ev_q.push_back('{1'b0, cyc});
    else if (err) ev_q.push_back('{1'b1, cyc});
    offs = cyc - poll_start;
    if (in_poll && (offs % 2 == 1))
      reg_rdata = ((offs / 2 + 1) >= cur_resp) ? cur_status : (8'($urandom) & 8'hFC);
    else
      reg_rdata = 8'($urandom);
    prev_we = reg_we; prev_busy = busy; prev_poll = in_poll;
    prev_addr = reg_addr; prev_data = reg_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic build_frame(input logic [7:0] idx, input logic [7:0] set,
                             input logic [31:0] arg, input int first_cyc);
    logic [7:0] b[6];
    b = '{idx, set, arg[31:24], arg[23:16], arg[15:8], arg[7:0]};
    for (int i = 0; i < 6; i++) exp_q.push_back('{7'(5 - i), b[i], first_cyc + 2 * i});
  endtask

  task automatic clear_mon();
    got_q.delete(); ev_q.delete(); viol = 0;
  endtask

  task automatic finish_txn(input int kind, input logic [31:0] blk, input int res,
                            input logic rdy, input string tag);
    int n, last, exp_cyc;
    n = 0;
    while (ev_q.size() == 0 && n < CMD0_WAIT + POLL_TIMEOUT + 200) begin
      @(negedge clk); n++;
    end
    chk($sformatf("%s completion seen", tag), ev_q.size() != 0, 1);
    repeat (3) @(negedge clk);
    exp_q.delete();
    if (kind != 1) begin
      build_frame(8'd0, 8'd0, 32'd0, origin + 1);
      build_frame(8'd7, CMD7_SET, {RCA, 16'h0000}, origin + 11 + CMD0_WAIT + 2);
    end else begin
      build_frame(8'd17, CMD17_SET, blk, origin + 1);
    end
    last = exp_q[exp_q.size() - 1].cyc;
    chk($sformatf("%s write count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s write[%0d] addr/data/cycle", tag, i),
          {got_q[i].addr, got_q[i].data, 32'(got_q[i].cyc)},
          {exp_q[i].addr, exp_q[i].data, 32'(exp_q[i].cyc)});
    exp_cyc = last + 1 + ((cur_status[1:0] == 2'b00) ? POLL_TIMEOUT : 2 * cur_resp);
    chk($sformatf("%s pulse count", tag), ev_q.size(), 1);
    if (ev_q.size() >= 1) begin
      chk($sformatf("%s pulse is err", tag), ev_q[0].is_err, (res == 1));
      chk($sformatf("%s pulse cycle", tag), ev_q[0].cyc, exp_cyc);
    end
    chk($sformatf("%s ready", tag), ready, rdy);
    chk($sformatf("%s busy after", tag), busy, 0);
    chk($sformatf("%s protocol violations", tag), viol, 0);
  endtask

  task automatic run_txn(input int kind, input logic [31:0] blk, input logic [7:0] st,
                         input int resp, input int res, input logic rdy, input string tag);
    cur_status = st; cur_resp = resp;
    clear_mon();
    @(negedge clk);
    rd_blk_addr = blk;
    init_req = (kind != 1);
    rd_req   = (kind != 0);
    @(negedge clk);
    init_req = 1'b0; rd_req = 1'b0;
    rd_blk_addr = $urandom;
    if (res == 2) begin
      chk($sformatf("%s reject err/busy", tag), {err, busy}, 2'b10);
      @(negedge clk);
      chk($sformatf("%s reject err one cycle", tag), err, 0);
      repeat (3) @(negedge clk);
      chk($sformatf("%s reject no writes", tag), got_q.size(), 0);
      chk($sformatf("%s reject pulse count", tag), ev_q.size(), 1);
      chk($sformatf("%s reject ready", tag), ready, rdy);
    end else begin
      chk($sformatf("%s accept busy/we/addr", tag), {busy, reg_we, reg_addr}, {1'b1, 1'b0, 7'd5});
      finish_txn(kind, blk, res, rdy, tag);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   n;
    tbl[0] = '{0, 32'h0000_0000, 8'h01, 3, 0, 1'b1};
    tbl[1] = '{1, 32'h0000_1234, 8'h01, 1, 0, 1'b1};
    tbl[2] = '{1, 32'hDEAD_BEEF, 8'h03, 2, 1, 1'b1};
    tbl[3] = '{1, 32'h0000_0000, 8'h00, 1, 1, 1'b1};
    tbl[4] = '{1, 32'h0000_00A5, 8'h81, 4, 0, 1'b1};
    tbl[5] = '{0, 32'h0000_0000, 8'h02, 1, 1, 1'b0};
    tbl[6] = '{1, 32'h0000_0055, 8'h01, 1, 2, 1'b0};
    tbl[7] = '{2, 32'h0000_0099, 8'h01, 2, 0, 1'b1};
    tbl[8] = '{0, 32'h0000_0000, 8'h00, 1, 1, 1'b0};
    tbl[9] = '{0, 32'h0000_0000, 8'h01, 1, 0, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset outputs", {ready, busy, done, err, reg_we, reg_addr, reg_wdata}, '0);
    rstn_async = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].kind, tbl[i].blk, tbl[i].st, tbl[i].resp, tbl[i].res, tbl[i].rdy,
              $sformatf("vec%0d", i));
      model_ready = tbl[i].rdy;
    end

    // Reset during a CMD7 strobe, then re-init accepted on the first edge after release.
    cur_status = 8'h01; cur_resp = 2;
    @(negedge clk); init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
    n = 0;
    while (!(reg_we && reg_addr == 7'd5 && reg_wdata == 8'd7) && n < 400) begin
      @(negedge clk); n++;
    end
    chk("reach CMD7 strobe", n < 400, 1);
    #1 rstn_async = 1'b0;
    #1 chk("async reset outputs", {ready, busy, done, err, reg_we, reg_addr, reg_wdata}, '0);
    init_req = 1'b1;
    @(negedge clk);
    clear_mon();
    #1 rstn_async = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    chk("post-reset accept busy/we/addr", {busy, reg_we, reg_addr}, {1'b1, 1'b0, 7'd5});
    finish_txn(0, 32'd0, 0, 1'b1, "post-reset init");
    model_ready = 1'b1;

    for (int i = 0; i < 16; i++) begin
      int          kind, resp, res;
      logic [31:0] blk;
      logic [7:0]  st;
      kind = $urandom_range(0, 2);
      blk  = $urandom;
      st   = 8'($urandom);
      if (st[1:0] == 2'b00) st[0] = 1'b1;
      resp = $urandom_range(1, 6);
      if (kind == 1 && !model_ready) res = 2;
      else res = st[1] ? 1 : 0;
      if (kind != 1) model_ready = (res == 0);
      run_txn(kind, blk, st, resp, res, model_ready, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
